// File: rtl/rv32_pkg.sv
// Shared PSRV32 definitions: NOP encoding, base opcodes used by decode, fetch FSM states.
// The TRAP state exists only when FETCH_MISALIGN_CHK_EN is defined.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        RST,
        FETCH,
        WAIT,
        HOLD
`ifdef FETCH_MISALIGN_CHK_EN
        , TRAP
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer catching a fetch response while decode stalls.
// Flush wins over fill; fill wins over drain.
module fetch_skid_buf
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fill,
    input  logic [31:0] fill_instr,
    input  logic [31:0] fill_pc,
    input  logic        drain,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            instr <= fill_instr;
            pc    <= fill_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PSRV32 instruction fetch: PC, single-outstanding imem requests, IF/ID register with skid.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign_o
`endif
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_pc_q;
    logic         kill_q;

    logic         skid_valid;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    logic [31:0]  target;
    logic         in_trap;
    logic         resp_ok;
    logic         out_free;
    logic         out_load;
    logic         skid_fill;
    logic         skid_drain;
    logic         kill_next;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = |redirect_pc_i[1:0];
    assign target     = redirect_pc_i;
    assign in_trap    = (state_q == TRAP);
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign target        = {redirect_pc_i[31:2], 2'b00};
    assign in_trap       = 1'b0;
`endif

    assign imem_req_o  = (state_q == FETCH);
    assign imem_addr_o = pc_q;

    assign resp_ok    = (state_q == WAIT) && imem_rvalid_i && !kill_q;
    assign out_free   = !instr_valid_o || !stall_i;
    assign out_load   = out_free && !in_trap;
    assign skid_fill  = resp_ok && !out_free && !redirect_i;
    assign skid_drain = skid_valid && !stall_i;

    // A response is still owed if a grant lands now, or one was pending and did not just return.
    assign kill_next = (imem_req_o && imem_gnt_i) ||
                       (((state_q == WAIT) || kill_q) && !imem_rvalid_i);

    fetch_skid_buf u_skid (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (redirect_i),
        .fill      (skid_fill),
        .fill_instr(imem_rdata_i),
        .fill_pc   (fetch_pc_q),
        .drain     (skid_drain),
        .valid     (skid_valid),
        .instr     (skid_instr),
        .pc        (skid_pc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= RST;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
            pc_o          <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_misalign_o <= 1'b0;
`endif
        end else if (redirect_i) begin
            pc_q    <= target;
            kill_q  <= kill_next;
            instr_o <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_misalign_o <= misaligned;
            if (misaligned) begin
                state_q       <= TRAP;
                instr_valid_o <= 1'b1;
                pc_o          <= redirect_pc_i;
            end else begin
                state_q       <= kill_next ? WAIT : FETCH;
                instr_valid_o <= 1'b0;
            end
`else
            state_q       <= kill_next ? WAIT : FETCH;
            instr_valid_o <= 1'b0;
`endif
        end else begin
            if (imem_rvalid_i) begin
                kill_q <= 1'b0;
            end

            // Skid has priority: it always holds the older instruction.
            if (out_load) begin
                if (skid_valid) begin
                    instr_valid_o <= 1'b1;
                    instr_o       <= skid_instr;
                    pc_o          <= skid_pc;
                end else if (resp_ok) begin
                    instr_valid_o <= 1'b1;
                    instr_o       <= imem_rdata_i;
                    pc_o          <= fetch_pc_q;
                end else begin
                    instr_valid_o <= 1'b0;
                    instr_o       <= NOP_INSTR;
                end
            end

            case (state_q)
                RST:   state_q <= FETCH;
                FETCH: begin
                    if (imem_gnt_i) begin
                        pc_q       <= pc_q + 32'd4;
                        fetch_pc_q <= pc_q;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= skid_fill ? HOLD : FETCH;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        state_q <= FETCH;
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                TRAP:    state_q <= TRAP;
`endif
                default: state_q <= RST;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an imem responder and a program-order model.
// Build with FETCH_MISALIGN_CHK_EN defined to exercise the misalignment trap.
module tb_fetch_stage;
    import rv32_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .stall_i      (stall),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .pc_o         (pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign_o(misalign)
`endif
    );

`ifndef FETCH_MISALIGN_CHK_EN
    assign misalign = 1'b0;
`endif

    // Instruction memory image: 0x100 holds addi x1,x0,5; everything else is address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[19:0] ^ 20'hABCDE, 12'h093};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: grants when idle, returns data lat cycles after the grant.
    logic        pending = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] gaddr = '0;
    int unsigned cnt = 0;
    int unsigned lat = 1;
    logic        corrupt = 1'b0;

    always @(negedge clk) begin
        imem_gnt    = !rst && imem_req && !pending;
        gaddr       = imem_addr;
        imem_rvalid = !rst && pending && (cnt == 0);
        imem_rdata  = corrupt ? 32'hDEAD_BEEF : mem_word(paddr);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 1'b0;
            cnt     = 0;
        end else begin
            if (imem_rvalid) pending = 1'b0;
            if (imem_gnt) begin
                pending = 1'b1;
                paddr   = gaddr;
                cnt     = lat - 1;
            end else if (pending && cnt != 0) begin
                cnt--;
            end
        end
    end

    // Program-order model sampled just before each rising edge.
    logic [31:0] exp_fetch = RPC;
    logic [31:0] exp_seq   = RPC;
    logic [31:0] tgt;
    logic        prev_redir = 1'b0;
    logic        prev_trap  = 1'b0;
    logic        trap_now;

    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            exp_fetch  = RPC;
            exp_seq    = RPC;
            prev_redir = 1'b0;
            prev_trap  = 1'b0;
        end else begin
            if (prev_redir && !prev_trap) chk("flush_after_redirect", instr_valid, 1'b0);
            if (imem_req) chk("single_outstanding", pending, 1'b0);
            if (misalign) begin
                chk("trap_no_req", imem_req, 1'b0);
                chk("trap_instr", instr, NOP_INSTR);
            end else begin
                if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
                if (instr_valid) begin
                    chk("seq_pc", pc, exp_seq);
                    chk("seq_instr", instr, mem_word(pc));
                end else begin
                    chk("idle_nop", instr, NOP_INSTR);
                end
            end
            if (redirect) begin
                tgt      = redirect_pc;
                trap_now = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                trap_now = (tgt[1:0] != 2'b00);
`else
                tgt[1:0] = 2'b00;
`endif
                exp_fetch  = tgt;
                exp_seq    = tgt;
                prev_redir = 1'b1;
                prev_trap  = trap_now;
            end else begin
                prev_redir = 1'b0;
                if (imem_req && imem_gnt) exp_fetch = exp_fetch + 32'd4;
                if (instr_valid && !stall && !misalign) exp_seq = exp_seq + 32'd4;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_req(input string name, input int unsigned bound);
        for (int unsigned i = 0; i < bound && !imem_req; i++) cyc();
        chk({name, "_req_timeout"}, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string name, input int unsigned bound);
        for (int unsigned i = 0; i < bound && !instr_valid; i++) cyc();
        chk({name, "_valid_timeout"}, instr_valid, 1'b1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        cyc();
        redirect    = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) cyc();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", pc, 32'h0);
        chk("rst_misalign", misalign, 1'b0);
        rst = 1'b0;

        // First fetch: request, response, valid in cycle 3
        cyc();
        chk("c1_req", imem_req, 1'b1);
        chk("c1_addr", imem_addr, 32'h0000_0100);
        cyc();
        chk("c2_no_req", imem_req, 1'b0);
        cyc();
        chk("c3_valid", instr_valid, 1'b1);
        chk("c3_instr", instr, 32'h0050_0093);
        chk("c3_pc", pc, 32'h0000_0100);
        chk("c3_addr", imem_addr, 32'h0000_0104);

        // Redirect with stall and a valid output, grant in flight
        stall = 1'b1;
        do_redirect(32'h0000_0000);
        chk("rs_valid", instr_valid, 1'b0);
        chk("rs_instr", instr, NOP_INSTR);
        cyc();
        chk("rs_req", imem_req, 1'b1);
        chk("rs_addr", imem_addr, 32'h0000_0000);

        // Stall across two responses: A in output, B in skid, HOLD
        repeat (2) cyc();
        chk("a_valid", instr_valid, 1'b1);
        chk("a_instr", instr, 32'hABCD_E093);
        chk("a_pc", pc, 32'h0000_0000);
        chk("b_addr", imem_addr, 32'h0000_0004);
        repeat (2) cyc();
        chk("hold_no_req", imem_req, 1'b0);
        chk("hold_instr", instr, 32'hABCD_E093);
        cyc();
        chk("hold2_no_req", imem_req, 1'b0);
        chk("hold2_pc", pc, 32'h0000_0000);
        stall = 1'b0;
        cyc();
        chk("b_instr", instr, 32'hABCD_A093);
        chk("b_pc", pc, 32'h0000_0004);
        chk("post_hold_req", imem_req, 1'b1);
        chk("post_hold_addr", imem_addr, 32'h0000_0008);
        repeat (6) cyc();

        // Redirect while waiting on a slow response; stale data must vanish
        lat = 3;
        for (int unsigned i = 0; i < 10 && pending; i++) cyc();
        for (int unsigned i = 0; i < 10 && !(pending && !imem_req); i++) cyc();
        chk("slow_wait_reached", pending, 1'b1);
        corrupt = 1'b1;
        do_redirect(32'h0000_2000);
        wait_req("kill", 10);
        chk("kill_addr", imem_addr, 32'h0000_2000);
        corrupt = 1'b0;
        wait_valid("kill", 20);
        chk("kill_first_pc", pc, 32'h0000_2000);
        chk("kill_first_instr", instr, 32'hA9CD_E093);
        lat = 1;
        repeat (4) cyc();

        // PC wrap
        do_redirect(32'hFFFF_FFFC);
        wait_req("wrap0", 10);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc();
        wait_req("wrap1", 10);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'h5432_2093);
        repeat (3) cyc();

        // Misaligned redirect
        do_redirect(32'h0000_1002);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_flag", misalign, 1'b1);
        chk("mis_valid", instr_valid, 1'b1);
        chk("mis_pc", pc, 32'h0000_1002);
        chk("mis_instr", instr, NOP_INSTR);
        repeat (4) cyc();
        chk("mis_no_req", imem_req, 1'b0);
        do_redirect(32'h0000_3000);
        chk("mis_clear", misalign, 1'b0);
        wait_req("mis_exit", 10);
        chk("mis_exit_addr", imem_addr, 32'h0000_3000);
`else
        wait_req("align", 10);
        chk("align_addr", imem_addr, 32'h0000_1000);
        wait_valid("align", 10);
        chk("align_pc", pc, 32'h0000_1000);
`endif
        repeat (3) cyc();

        // Reset in the middle of a transaction
        for (int unsigned i = 0; i < 10 && !pending; i++) cyc();
        chk("midrst_pending", pending, 1'b1);
        rst = 1'b1;
        cyc();
        chk("midrst_valid", instr_valid, 1'b0);
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_addr", imem_addr, RPC);
        rst = 1'b0;
        cyc();
        chk("midrst_req1", imem_req, 1'b1);
        chk("midrst_addr1", imem_addr, RPC);
        repeat (2) cyc();
        chk("midrst_valid3", instr_valid, 1'b1);
        chk("midrst_instr3", instr, 32'h0050_0093);
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
